// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit: FSM state
// encodings, supported opcodes, ALUOp/ALUControl codes and the mux select
// codes driven onto the datapath.
// No ports (package only).

package riscv_ctrl_pkg;

  localparam int ALU_CTRL_W = 3;
  localparam int ST_W       = 4;

  // 11 states in a 4-bit register; the remaining 5 encodings are treated as
  // corrupt and steer the FSM back to FETCH.
  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/riscv_multicycle_ctrl_alu_dec.sv
// riscv_alu_dec
// Combinational ALU decoder: maps ALUOp plus instruction fields to the
// 3-bit ALUControl code and reports whether funct3 names an ALU operation
// this core implements.
// Ports:
//   aluOp_i        2-bit ALUOp from the control FSM
//   funct3_i       instruction funct3
//   opB5_i         opcode bit 5 (distinguishes R-type from I-type)
//   funct7b5_i     instruction bit 30
//   aluControl_o   ALU operation code
//   functIllegal_o funct3 is not add/sub, slt, or, and

module riscv_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0]            aluOp_i,
  input  logic [2:0]            funct3_i,
  input  logic                  opB5_i,
  input  logic                  funct7b5_i,
  output logic [ALU_CTRL_W-1:0] aluControl_o,
  output logic                  functIllegal_o
);

  // The funct3 check is independent of aluOp_i so the FSM can flag a bad
  // R/I instruction in DECODE, where ALUOp is still "add".
  always_comb begin
    functIllegal_o = 1'b0;
    case (funct3_i)
      3'b000, 3'b010, 3'b110, 3'b111: functIllegal_o = 1'b0;
      default:                        functIllegal_o = 1'b1;
    endcase
  end

  // Only R-type with bit 30 set subtracts; addi with bit 30 set still adds
  // because bit 30 is part of its immediate.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (aluOp_i)
      ALUOP_ADD: aluControl_o = ALU_ADD;
      ALUOP_SUB: aluControl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  aluControl_o = (opB5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl_o = ALU_SLT;
          3'b110:  aluControl_o = ALU_OR;
          3'b111:  aluControl_o = ALU_AND;
          default: aluControl_o = ALU_ADD;
        endcase
      end
      default: aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Control unit for the multicycle RISC-V datapath. A Moore FSM sequences
// fetch/decode/execute/memory/writeback for lw, sw, R-type, I-type ALU, beq
// and jal. ImmSrc, ALUControl, PCWrite and IllegalInstr also depend on the
// instruction fields / Zero flag.
// Configuration macro: BNE_SUPPORT_EN -- when defined the branch state also
// executes bne (funct3 001, taken on ~Zero); otherwise only beq is legal.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   op, funct3, funct7b5    instruction register fields
//   Zero                    ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegWrite, ALUControl   datapath controls
//   IllegalInstr            unsupported instruction seen in DECODE

module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  Zero,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  IllegalInstr
);

  state_e     state_q, state_d;
  logic [1:0] aluOp;
  logic       pcUpdate;
  logic       branch;
  logic       branchTaken;
  logic       branchFunctOk;
  logic       functIllegal;

  riscv_alu_dec u_alu_dec (
    .aluOp_i       (aluOp),
    .funct3_i      (funct3),
    .opB5_i        (op[5]),
    .funct7b5_i    (funct7b5),
    .aluControl_o  (ALUControl),
    .functIllegal_o(functIllegal)
  );

  // Branch flavour selection: bne inverts the sense of Zero.
`ifdef BNE_SUPPORT_EN
  assign branchFunctOk = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign branchTaken   = (funct3 == 3'b001) ? ~Zero : Zero;
`else
  assign branchFunctOk = (funct3 == 3'b000);
  assign branchTaken   = Zero;
`endif

  assign PCWrite = pcUpdate | (branch & branchTaken);

  // Immediate format follows the opcode in every state so it is stable
  // from DECODE onward.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next state and Moore outputs. An illegal instruction in DECODE returns
  // straight to FETCH without touching registers or memory.
  always_comb begin
    state_d      = S_FETCH;
    aluOp        = ALUOP_ADD;
    pcUpdate     = 1'b0;
    branch       = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    RegWrite     = 1'b0;
    IllegalInstr = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pcUpdate  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            IllegalInstr = functIllegal;
            state_d      = functIllegal ? S_FETCH : S_EXECUTER;
          end
          OP_I: begin
            IllegalInstr = functIllegal;
            state_d      = functIllegal ? S_FETCH : S_EXECUTEI;
          end
          OP_BEQ: begin
            IllegalInstr = ~branchFunctOk;
            state_d      = branchFunctOk ? S_BEQ : S_FETCH;
          end
          OP_JAL: state_d = S_JAL;
          default: begin
            IllegalInstr = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        aluOp   = ALUOP_SUB;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pcUpdate = 1'b1;
        state_d  = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl
// Directed-vector bench for riscv_multicycle_ctrl. All control outputs are
// packed into one 17-bit vector and compared against hand-built values
// once per cycle on the falling clock edge.

module tb_riscv_multicycle_ctrl;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [16:0] ctrl;

  int totalChecks;
  int badChecks;

  riscv_multicycle_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .Zero        (Zero),
    .PCWrite     (PCWrite),
    .AdrSrc      (AdrSrc),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .ResultSrc   (ResultSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ImmSrc      (ImmSrc),
    .RegWrite    (RegWrite),
    .ALUControl  (ALUControl),
    .IllegalInstr(IllegalInstr)
  );

  assign ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ImmSrc, RegWrite, ALUControl, IllegalInstr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds an expected control vector in the same field order as ctrl.
  function automatic logic [16:0] mk(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm,
                                     input logic rw, input logic [2:0] aluc,
                                     input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, aluc, ill};
  endfunction

  function automatic logic [16:0] fetchVec(input logic [1:0] imm);
    return mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 0, 3'b000, 0);
  endfunction

  function automatic logic [16:0] decodeVec(input logic [1:0] imm, input logic ill);
    return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, 3'b000, ill);
  endfunction

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [16:0] got,
                             input logic [16:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drives the instruction fields and the Zero flag.
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
  endtask

  // Advances one clock and checks the outputs of the new state.
  task automatic stepCheck(input string tag, input logic [16:0] exp);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag, ctrl, exp);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset_n     = 1'b0;
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.fetch", ctrl, fetchVec(2'b00));
    reset_n = 1'b1;
    checkOutput("release.fetch", ctrl, fetchVec(2'b00));

    // lw: 5 cycles
    stepCheck("lw.decode",  decodeVec(2'b00, 0));
    stepCheck("lw.memadr",  mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0));
    stepCheck("lw.memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
    stepCheck("lw.memwb",   mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
    stepCheck("lw.fetch",   fetchVec(2'b00));

    // sw: 4 cycles
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
    stepCheck("sw.decode",   decodeVec(2'b01, 0));
    stepCheck("sw.memadr",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0));
    stepCheck("sw.memwrite", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0));
    stepCheck("sw.fetch",    fetchVec(2'b01));

    // R-type sub
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
    stepCheck("sub.decode", decodeVec(2'b00, 0));
    stepCheck("sub.exec",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001, 0));
    stepCheck("sub.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
    stepCheck("sub.fetch",  fetchVec(2'b00));

    // R-type slt
    applyStimulus(7'b0110011, 3'b010, 1'b0, 1'b0);
    stepCheck("slt.decode", decodeVec(2'b00, 0));
    stepCheck("slt.exec",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b101, 0));
    stepCheck("slt.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
    stepCheck("slt.fetch",  fetchVec(2'b00));

    // R-type and
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0);
    stepCheck("and.decode", decodeVec(2'b00, 0));
    stepCheck("and.exec",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b010, 0));
    stepCheck("and.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
    stepCheck("and.fetch",  fetchVec(2'b00));

    // addi with bit 30 set still adds
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0);
    stepCheck("addi.decode", decodeVec(2'b00, 0));
    stepCheck("addi.exec",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0));
    stepCheck("addi.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
    stepCheck("addi.fetch",  fetchVec(2'b00));

    // ori
    applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0);
    stepCheck("ori.decode", decodeVec(2'b00, 0));
    stepCheck("ori.exec",   mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b011, 0));
    stepCheck("ori.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0));
    stepCheck("ori.fetch",  fetchVec(2'b00));

    // beq taken: 3 cycles
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
    stepCheck("beqT.decode", decodeVec(2'b10, 0));
    stepCheck("beqT.beq",    mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0));
    stepCheck("beqT.fetch",  fetchVec(2'b10));

    // beq not taken
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
    stepCheck("beqN.decode", decodeVec(2'b10, 0));
    stepCheck("beqN.beq",    mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0));
    stepCheck("beqN.fetch",  fetchVec(2'b10));

    // Branch with funct3 001 (bne), Zero=0
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0);
`ifdef BNE_SUPPORT_EN
    stepCheck("bne.decode", decodeVec(2'b10, 0));
    stepCheck("bne.br",     mk(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0));
    stepCheck("bne.fetch",  fetchVec(2'b10));
`else
    stepCheck("bne.decode", decodeVec(2'b10, 1));
    stepCheck("bne.fetch",  fetchVec(2'b10));
`endif

    // jal: 4 cycles
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
    stepCheck("jal.decode", decodeVec(2'b11, 0));
    stepCheck("jal.jal",    mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000, 0));
    stepCheck("jal.aluwb",  mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 3'b000, 0));
    stepCheck("jal.fetch",  fetchVec(2'b11));

    // Unsupported opcode: 2 cycles
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
    stepCheck("ill.decode", decodeVec(2'b00, 1));
    stepCheck("ill.fetch",  fetchVec(2'b00));

    // Asynchronous reset in the middle of MEMREAD
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
    stepCheck("rst2.decode",  decodeVec(2'b00, 0));
    stepCheck("rst2.memadr",  mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0));
    stepCheck("rst2.memread", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0));
    #1 reset_n = 1'b0;
    #1 checkOutput("rst2.async", ctrl, fetchVec(2'b00));
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst2.held", ctrl, fetchVec(2'b00));
    reset_n = 1'b1;
    stepCheck("rst2.decode2", decodeVec(2'b00, 0));

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
